// File: rtl/pkg_reg.sv
`default_nettype none
// ============================================================================
// Module      : pkg_reg
// Description : Shared sizes and state encodings for the ULM register file.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_reg;

    localparam int REG_WIDTH  = 64;
    localparam int REG_ADDR_W = 8;

    typedef enum logic {
        RF_CLEAR,
        RF_READY
    } rf_state_t;

    // Source of a read port's output value, latched at the read edge.
    typedef enum logic [1:0] {
        RD_ZERO = 2'd0,
        RD_BYP  = 2'd1,
        RD_MEM  = 2'd2
    } rd_sel_t;

endpackage
`default_nettype wire

// File: rtl/ram_1r1w.sv
`default_nettype none
// ============================================================================
// Module      : ram_1r1w
// Description : Simple dual-port RAM, one write port and one registered read
//               port, no reset (maps onto iCE40 block RAM).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_1r1w #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int C_DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] r_mem [C_DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read data holds while re is low so the owner can keep its output stable.
    always_ff @(posedge clk) begin
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dev_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : dev_reg_file
// Description : Two-read / one-write general-purpose register file with r0
//               hard-wired to zero, write-first bypass and post-reset clear.
// Revision    : 1.0 - initial release
// ============================================================================
module dev_reg_file
    import pkg_reg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic              rd_a_en,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [WIDTH-1:0]  rd_a_data,
    input  logic              rd_b_en,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [WIDTH-1:0]  rd_b_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;

    rf_state_t         r_state;
    rf_state_t         w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [WIDTH-1:0]  w_mem_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // The reset edge itself must not touch the array, hence the !rst gating.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_mem_we     = 1'b0;
        w_mem_waddr  = wr_addr;
        w_mem_wdata  = wr_data;
        case (r_state)
            RF_CLEAR: begin
                w_mem_we    = !rst;
                w_mem_waddr = r_ptr;
                w_mem_wdata = '0;
                w_ptr_next  = r_ptr + ADDR_W'(1);
                if (r_ptr == C_LAST_ADDR) begin
                    w_state_next = RF_READY;
                end
            end
            RF_READY: begin
                w_mem_we = !rst && wr_en && (wr_addr != '0);
            end
            default: begin
                w_state_next = RF_CLEAR;
            end
        endcase
    end

    assign busy = (r_state == RF_CLEAR);

    logic [1:0]        w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [WIDTH-1:0]  w_rd_data [2];

    assign w_rd_en      = {rd_b_en, rd_a_en};
    assign w_rd_addr[0] = rd_a_addr;
    assign w_rd_addr[1] = rd_b_addr;
    assign rd_a_data    = w_rd_data[0];
    assign rd_b_data    = w_rd_data[1];

    for (genvar p = 0; p < 2; p++) begin : g_port
        rd_sel_t          r_sel;
        logic [WIDTH-1:0] r_byp;
        logic [WIDTH-1:0] w_ram_q;
        logic             w_re;

        assign w_re = (r_state == RF_READY) && w_rd_en[p] && !rst;

        // The output source is chosen at the read edge; RAM data arrives one
        // edge later, so the final mux sits behind registers only.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sel <= RD_ZERO;
            end else if (w_re) begin
                if (w_rd_addr[p] == '0) begin
                    r_sel <= RD_ZERO;
                end else if (wr_en && (wr_addr == w_rd_addr[p])) begin
                    r_sel <= RD_BYP;
                    r_byp <= wr_data;
                end else begin
                    r_sel <= RD_MEM;
                end
            end
        end

        ram_1r1w #(
            .WIDTH  (WIDTH),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .we    (w_mem_we),
            .waddr (w_mem_waddr),
            .wdata (w_mem_wdata),
            .re    (w_re),
            .raddr (w_rd_addr[p]),
            .rdata (w_ram_q)
        );

        assign w_rd_data[p] = (r_sel == RD_BYP) ? r_byp :
                              (r_sel == RD_MEM) ? w_ram_q : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_dev_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_dev_reg_file
// Description : Self-checking bench for dev_reg_file against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dev_reg_file;

    localparam int W  = 64;
    localparam int AW = 8;
    localparam int N  = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic          rd_a_en, rd_b_en, wr_en;
    logic [AW-1:0] rd_a_addr, rd_b_addr, wr_addr;
    logic [W-1:0]  rd_a_data, rd_b_data, wr_data;

    int checks = 0;
    int errors = 0;

    dev_reg_file #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .rd_a_en   (rd_a_en),
        .rd_a_addr (rd_a_addr),
        .rd_a_data (rd_a_data),
        .rd_b_en   (rd_b_en),
        .rd_b_addr (rd_b_addr),
        .rd_b_data (rd_b_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    // Behavioural model: registers as a plain array, clear as a countdown.
    logic [W-1:0] m_mem [N];
    int           m_clear_left = N;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_clear_left = N;
            m_a = '0;
            m_b = '0;
            for (int i = 0; i < N; i++) m_mem[i] = '0;
            m_valid = 1'b1;
        end else if (m_clear_left > 0) begin
            m_clear_left = m_clear_left - 1;
        end else begin
            // Write-first semantics: reads in this cycle observe this write.
            if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
            if (rd_a_en) m_a = (rd_a_addr == 0) ? '0 : m_mem[rd_a_addr];
            if (rd_b_en) m_b = (rd_b_addr == 0) ? '0 : m_mem[rd_b_addr];
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks = checks + 3;
            if (busy !== (m_clear_left > 0)) begin
                errors = errors + 1;
                $display("FAIL model_busy: got %0b want %0b at %0t", busy, (m_clear_left > 0), $time);
            end
            if (rd_a_data !== m_a) begin
                errors = errors + 1;
                $display("FAIL model_rd_a: got %h want %h at %0t", rd_a_data, m_a, $time);
            end
            if (rd_b_data !== m_b) begin
                errors = errors + 1;
                $display("FAIL model_rd_b: got %h want %h at %0t", rd_b_data, m_b, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus; returns at the negedge after the edge that used it.
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic ae, input logic [AW-1:0] aa,
                       input logic be, input logic [AW-1:0] ba);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_a_en = ae; rd_a_addr = aa;
        rd_b_en = be; rd_b_addr = ba;
        @(negedge clk);
    endtask

    // Release reset and count cycles with busy high, bounded.
    task automatic release_and_count(output int cnt);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) break;
            cnt = cnt + 1;
            @(negedge clk);
        end
    endtask

    int busy_cycles;

    initial begin
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("reset_busy", {63'd0, busy}, 64'd1);
        chk("reset_rd_a", rd_a_data, 64'd0);
        chk("reset_rd_b", rd_b_data, 64'd0);

        release_and_count(busy_cycles);
        chk("clear_cycles", 64'(busy_cycles), 64'd256);

        for (int i = 0; i < N; i++) begin
            cyc(0, 0, 0, 1, AW'(i), 1, AW'(N - 1 - i));
            chk("cleared_a", rd_a_data, 64'd0);
        end

        cyc(1, 5, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 5, 1, 5);
        chk("r5_a", rd_a_data, 64'h0123_4567_89AB_CDEF);
        chk("r5_b", rd_b_data, 64'h0123_4567_89AB_CDEF);

        cyc(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 5);
        chk("r0_after_write", rd_a_data, 64'd0);
        cyc(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 0);
        chk("r0_same_cycle_a", rd_a_data, 64'd0);
        chk("r0_same_cycle_b", rd_b_data, 64'd0);

        cyc(1, 8, 64'h99, 0, 0, 0, 0);
        cyc(1, 7, 64'h42, 1, 7, 1, 8);
        chk("bypass_a_r7", rd_a_data, 64'h42);
        chk("array_b_r8", rd_b_data, 64'h99);
        cyc(0, 0, 0, 1, 7, 0, 0);
        chk("later_r7", rd_a_data, 64'h42);

        cyc(1, 5, 64'h11, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 5, 0, 0);
        chk("hold_start", rd_a_data, 64'h11);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5, 64'h22, 0, 5, 0, 0);
            chk("hold_a", rd_a_data, 64'h11);
        end
        cyc(0, 0, 0, 1, 5, 1, 7);
        chk("after_hold_r5", rd_a_data, 64'h22);
        chk("after_hold_r7", rd_b_data, 64'h42);

        // Interrupt a clear at pointer 100 with writes pending throughout.
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) cyc(1, 9, 64'hDEAD_BEEF, 1, 9, 1, 9);
        chk("busy_at_ptr100", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        cyc(1, 9, 64'hDEAD_BEEF, 1, 9, 1, 9);
        release_and_count(busy_cycles);
        chk("restart_cycles", 64'(busy_cycles), 64'd256);
        cyc(0, 0, 0, 1, 9, 1, 5);
        chk("r9_not_written", rd_a_data, 64'd0);
        chk("r5_recleared", rd_b_data, 64'd0);

        cyc(0, 0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
